// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths and FSM state encoding for the instruction memory loader.
package imem_loader_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;
  localparam int LANE_W = 2;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_COMMIT, S_DONE, S_DRAIN, S_ERROR
  } state_t;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles four accepted bytes into a little-endian word with a one-cycle valid pulse.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_vld
);
  logic [LANE_W-1:0] r_lane;
  logic [WORD_W-1:0] r_sh;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane   <= '0;
      r_sh     <= '0;
      word     <= '0;
      word_vld <= 1'b0;
    end else if (clr) begin
      r_lane   <= '0;
      r_sh     <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= byte_vld && (r_lane == '1);
      if (byte_vld) begin
        r_lane <= r_lane + 1'b1;
        r_sh   <= {byte_in, r_sh[WORD_W-1:BYTE_W]};
        if (r_lane == '1) word <= {byte_in, r_sh[WORD_W-1:BYTE_W]};
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into IMEM as 32-bit words and
// holds the CPU in reset until a complete image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MEM_BYTES = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n,
  output logic [LEN_W-1:0]  words_loaded
);
  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(MEM_BYTES / 4);
  state_t             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W+1:0]   r_cnt;
  logic [31:0]        r_addr;
  logic [LEN_W-1:0]   r_words;
  logic               w_acc, w_start, w_last;
  logic [LEN_W-1:0]   w_len;
  logic [LEN_W+1:0]   w_cnt_nx;
  assign in_ready  = r_state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_DRAIN};
  assign busy      = r_state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_COMMIT, S_DRAIN};
  assign done      = r_state == S_DONE;
  assign err       = r_state == S_ERROR;
  assign cpu_rst_n = r_state == S_DONE;
  assign w_acc     = in_valid && in_ready;
  assign w_start   = start && (r_state inside {S_IDLE, S_DONE, S_ERROR});
  assign w_len     = {in_data, r_len[BYTE_W-1:0]};
  assign w_cnt_nx  = r_cnt + 1'b1;
  assign w_last    = w_cnt_nx == {r_len, 2'b00};
  assign mem_addr     = r_addr;
  assign words_loaded = r_words;
  // The packer's registered pulse lines up with the address/count updates made on the lane-3 edge.
  imem_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_start),
    .byte_vld (w_acc && r_state == S_DATA),
    .byte_in  (in_data),
    .word     (mem_wdata),
    .word_vld (mem_we)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_words <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: if (w_start) begin
          r_state <= S_LEN_LO;
          r_cnt   <= '0;
          r_words <= '0;
        end
        S_LEN_LO: if (w_acc) begin
          r_len[BYTE_W-1:0] <= in_data;
          r_state           <= S_LEN_HI;
        end
        S_LEN_HI: if (w_acc) begin
          r_len   <= w_len;
          r_cnt   <= '0;
          r_state <= (w_len == '0) ? S_DONE : (w_len > MAX_WORDS) ? S_DRAIN : S_DATA;
        end
        S_DATA: if (w_acc) begin
          r_cnt <= w_cnt_nx;
          if (r_cnt[1:0] == 2'd3) begin
            r_addr  <= BASE_ADDR + {14'd0, r_cnt[LEN_W+1:2], 2'b00};
            r_words <= r_words + 1'b1;
          end
          if (w_last) r_state <= S_COMMIT;
        end
        S_COMMIT: r_state <= S_DONE;
        S_DRAIN: if (w_acc) begin
          r_cnt <= w_cnt_nx;
          if (w_last) r_state <= S_ERROR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream over a valid/ready interface and writes it into a writable instruction RAM as 32-bit little-endian words.
- Word format matches the fetch-side view: byte at address+0 is the LSB.
- Sits between the host link (UART/debug byte source) and the IMEM write port.
- Holds the CPU in reset until a complete, valid image has been loaded.

Parameters:
- MEM_BYTES, 128, instruction memory size in bytes. MAX_WORDS = MEM_BYTES/4.
- BASE_ADDR, 0, byte address of the first written word. Must be 4-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  byte-source data valid.
- in_data  in  8  byte from the source.
- in_ready  out  1  loader accepts a byte. Transfer occurs on a clock edge where in_valid && in_ready.
- mem_we  out  1  one-cycle word write strobe to the IMEM.
- mem_addr  out  32  byte address of the write, always 4-aligned.
- mem_wdata  out  32  {b3,b2,b1,b0}; b0 is the first byte received for that word.
- busy  out  1  high in LEN_LO, LEN_HI, DATA, COMMIT and DRAIN.
- done  out  1  high in DONE.
- err  out  1  high in ERROR.
- cpu_rst_n  out  1  CPU reset, active-low. Released (1) only in DONE.
- words_loaded  out  16  count of words written in the current load.

Behaviour:
- Reset (asynchronous, rst_n=0), in any state including mid-load:
  - State goes to IDLE.
  - All outputs are 0, including cpu_rst_n=0 and words_loaded=0.
  - The partial word and the byte counter are cleared.
- Stream format:
  - Byte 0 = N[7:0], byte 1 = N[15:8] (N = word count).
  - Then 4*N data bytes, LSB of each word first.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, COMMIT, DONE, DRAIN, ERROR.
- IDLE: in_ready=0. start → LEN_LO next cycle; words_loaded and the word index are cleared on that edge.
- LEN_LO / LEN_HI: in_ready=1. Each accepted byte advances the state. On the LEN_HI accept:
  - N=0 → DONE.
  - N>MAX_WORDS → DRAIN.
  - Otherwise → DATA.
- DATA:
  - in_ready=1. A byte lane counter (0..3) places each accepted byte.
  - On acceptance of lane 3 of word i, in the next cycle: mem_we=1, mem_addr=BASE_ADDR+4*i, mem_wdata=assembled word; words_loaded increments on the same edge that raises mem_we.
  - mem_we is a one-cycle pulse; mem_addr and mem_wdata hold their last value afterwards.
  - When lane 3 of word N-1 is accepted → COMMIT.
- COMMIT: one cycle, in_ready=0. The final mem_we pulse occurs in this cycle. Next state is DONE.
- DONE: done=1, cpu_rst_n=1, in_ready=0. cpu_rst_n therefore rises the cycle after the last write strobe. start → LEN_LO and cpu_rst_n drops back to 0 on that edge.
- DRAIN: in_ready=1. Accepts and discards exactly 4*N bytes with no mem_we, then → ERROR.
- ERROR: err=1, cpu_rst_n=0, in_ready=0. start → LEN_LO.
- start while busy is ignored.
- in_valid low stalls the FSM indefinitely with no timeout. A partial word is never written.
- Back-to-back bytes at full rate (one per cycle) are supported with no bubbles except COMMIT.
- Counters:
  - Data byte counter is 18 bits (max 4*65535).
  - Address arithmetic is 32-bit modulo 2^32.

Decomposition:
- Package imem_loader_pkg:
  - state enum (8 states).
  - BYTE_W=8, WORD_W=32, LEN_W=16.
  - LANE_W=2.
- Sub-module imem_word_packer: lane counter plus 32-bit shift/assemble register.
  - Inputs: clk, rst_n, clr, byte_vld, byte.
  - Outputs: word, word_vld (1-cycle pulse on lane-3 accept).
- The FSM, address generation and cpu_rst_n control stay in imem_loader.

Test Plan:
- Reset: rst_n=0 with in_valid=1 → in_ready=0, mem_we=0, cpu_rst_n=0, all outputs 0. No state change until start.
- Normal load: start, then bytes 02 00, 33 80 F0 00, 33 01 F1 40 at one byte per cycle →
  - mem_we at addr 0x0 data 0x00F08033.
  - mem_we at addr 0x4 data 0x40F10133.
  - words_loaded=2, then done=1 and cpu_rst_n=1 one cycle after the second strobe.
- Backpressure: same image with in_valid toggling randomly → identical writes and data. No write while a word is incomplete.
- Zero length: start, bytes 00 00 → DONE immediately, no mem_we, cpu_rst_n=1.
- Overflow: MEM_BYTES=128, N=0x0021 (33 words) → DRAIN accepts 132 bytes with no mem_we, then err=1, cpu_rst_n=0. A following start plus a valid 1-word image → done=1.
- Reset mid-load: assert rst_n=0 after 5 data bytes → all outputs 0 immediately (asynchronously). Restart with a 1-word image writes only addr 0x0.
